// File: rtl/dump_if.sv
// Dump handshake bundle between the capture unit, command processor, UART TX and dump_sender.
// Handshake: send_dump is a level that holds ram_rdata valid until the one-cycle dump_sent pulse that closes the transfer.
interface dump_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 10
);
    logic              dump_req;
    logic              start_dump;
    logic              send_dump;
    logic [DATA_W-1:0] ram_rdata;
    logic              dump_sent;
    logic              dump_finished;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_done;
    logic              busy;
    logic              done;
    logic              error;
    logic [CNT_W-1:0]  byte_cnt;

    modport slave (
        input  dump_req, send_dump, ram_rdata, dump_finished, tx_done,
        output start_dump, dump_sent, tx_data, tx_start, busy, done, error, byte_cnt
    );

    modport master (
        output dump_req, send_dump, ram_rdata, dump_finished, tx_done,
        input  start_dump, dump_sent, tx_data, tx_start, busy, done, error, byte_cnt
    );
endinterface

// File: rtl/dump_sender.sv
// Consumer end of the capture dump: forwards each offered RAM byte to the UART and
// closes the dump with an ACK byte, or a NAK byte if the capture unit stalls.
module dump_sender #(
    parameter int                 DATA_W   = 8,
    parameter int                 CNT_W    = 10,
    parameter int                 TIMEOUT  = 4096,
    parameter logic [DATA_W-1:0]  ACK_BYTE = 8'hA5,
    parameter logic [DATA_W-1:0]  NAK_BYTE = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    dump_if.slave      bus,
    output logic [2:0] dbg_state
);
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        TX_WAIT   = 3'd2,
        ACK_WAIT  = 3'd3,
        NAK_WAIT  = 3'd4
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            bus.start_dump <= 1'b0;
            bus.dump_sent  <= 1'b0;
            bus.tx_start   <= 1'b0;
            bus.tx_data    <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            bus.byte_cnt   <= '0;
        end else begin
            bus.start_dump <= 1'b0;
            bus.dump_sent  <= 1'b0;
            bus.tx_start   <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.dump_req) begin
                        bus.start_dump <= 1'b1;
                        bus.busy       <= 1'b1;
                        bus.byte_cnt   <= '0;
                        timer          <= '0;
                        state          <= WAIT_DATA;
                    end
                end

                WAIT_DATA: begin
                    // While dump_sent is high the capture unit may still show the old
                    // send_dump level, so it is masked for that one cycle.
                    if (bus.dump_finished) begin
                        bus.tx_data  <= ACK_BYTE;
                        bus.tx_start <= 1'b1;
                        state        <= ACK_WAIT;
                    end else if (bus.send_dump && !bus.dump_sent) begin
                        bus.tx_data  <= bus.ram_rdata;
                        bus.tx_start <= 1'b1;
                        state        <= TX_WAIT;
                    end else if (timer == TMR_LAST) begin
                        bus.tx_data  <= NAK_BYTE;
                        bus.tx_start <= 1'b1;
                        state        <= NAK_WAIT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                TX_WAIT: begin
                    if (bus.tx_done) begin
                        bus.dump_sent <= 1'b1;
                        if (bus.byte_cnt != {CNT_W{1'b1}})
                            bus.byte_cnt <= bus.byte_cnt + CNT_W'(1);
                        timer <= '0;
                        state <= WAIT_DATA;
                    end
                end

                ACK_WAIT: begin
                    if (bus.tx_done) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end

                NAK_WAIT: begin
                    if (bus.tx_done) begin
                        bus.error <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dump_sender.sv
// Directed bench for dump_sender: capture-unit and UART models around the DUT,
// with a byte scoreboard on the UART side.
module tb_dump_sender;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 10;
    localparam int TIMEOUT = 4096;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dump_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();
    logic [2:0] dbg_state;

    logic uart_done = 1'b0;
    logic tb_done   = 1'b0;
    logic uart_en   = 1'b1;
    int   uart_delay = 3;
    assign bus.tx_done = uart_done | tb_done;

    dump_sender #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT),
        .ACK_BYTE(8'hA5), .NAK_BYTE(8'hEE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_start = 0, n_sent = 0, n_done = 0, n_err = 0;
    longint cyc = 0;
    longint done_cyc = 0;
    logic [DATA_W-1:0] tx_q[$];
    logic [DATA_W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // monitor
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) tx_q.push_back(bus.tx_data);
        if (bus.start_dump === 1'b1) n_start++;
        if (bus.dump_sent === 1'b1) n_sent++;
        if (bus.done === 1'b1) n_done++;
        if (bus.error === 1'b1) n_err++;
    end

    // UART model: tx_done raised uart_delay cycles after tx_start is seen
    initial begin
        forever begin
            @(negedge clk);
            if (uart_en && bus.tx_start === 1'b1) begin
                repeat (uart_delay) @(negedge clk);
                uart_done = 1'b1;
                done_cyc  = cyc;
                @(negedge clk);
                uart_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=end_of_test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_tx(input string tag);
        logic [31:0] o;
        logic [31:0] e;
        #1;
        while (exp_q.size() > 0) begin
            e = 32'(exp_q.pop_front());
            o = 'x;
            if (tx_q.size() > 0) o = 32'(tx_q.pop_front());
            check(tag, o, e);
        end
        check({tag, "_extra"}, tx_q.size(), 0);
    endtask

    // driver tasks: each starts and ends just after a falling edge
    task automatic req();
        bus.dump_req = 1'b1;
        @(negedge clk);
        bus.dump_req = 1'b0;
    endtask

    task automatic send_byte(input logic [DATA_W-1:0] b);
        bit got = 0;
        bus.send_dump = 1'b1;
        bus.ram_rdata = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.dump_sent === 1'b1) begin
                got = 1;
                break;
            end
        end
        bus.send_dump = 1'b0;
        if (!got) check("dump_sent_seen", 32'(got), 1);
    endtask

    task automatic finish_dump();
        bit got = 0;
        bus.dump_finished = 1'b1;
        @(negedge clk);
        bus.dump_finished = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1;
                break;
            end
        end
        check("done_seen", 32'(got), 1);
    endtask

    initial begin
        int s_start, s_sent, s_done, s_err;
        int k, starts, sents, st_i;
        longint sent_cyc;
        bit got;

        bus.dump_req      = 1'b0;
        bus.send_dump     = 1'b0;
        bus.ram_rdata     = '0;
        bus.dump_finished = 1'b0;

        // reset
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_byte_cnt", bus.byte_cnt, 0);
        check("rst_state", dbg_state, 0);
        check("rst_start_dump", bus.start_dump, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: three bytes then ACK
        s_sent = n_sent; s_done = n_done; s_err = n_err;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'hA5};
        req();
        check("t1_start_dump", bus.start_dump, 1);
        check("t1_busy", bus.busy, 1);
        check("t1_cnt0", bus.byte_cnt, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        finish_dump();
        check("t1_byte_cnt", bus.byte_cnt, 3);
        check("t1_busy_low", bus.busy, 0);
        #1;
        check("t1_sent_pulses", n_sent - s_sent, 3);
        check("t1_done_pulses", n_done - s_done, 1);
        check("t1_no_error", n_err - s_err, 0);
        check_tx("t1_tx");
        @(negedge clk);

        // 2: send_dump held through a slow UART
        exp_q = '{8'h5A, 8'hA5};
        req();
        uart_delay = 30;
        bus.ram_rdata = 8'h5A;
        bus.send_dump = 1'b1;
        starts = 0; sents = 0; st_i = -1; sent_cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                starts++;
                st_i = i;
            end
            if (bus.dump_sent === 1'b1) begin
                sents++;
                sent_cyc = cyc;
                bus.send_dump = 1'b0;
            end
        end
        bus.send_dump = 1'b0;
        check("t2_tx_starts", starts, 1);
        check("t2_sent_pulses", sents, 1);
        check("t2_tx_latency", st_i, 1);
        check("t2_sent_latency", 32'(sent_cyc - done_cyc), 1);
        check("t2_byte_cnt", bus.byte_cnt, 1);
        uart_delay = 3;
        finish_dump();
        check_tx("t2_tx");
        @(negedge clk);

        // 3: stalled dump -> NAK
        s_done = n_done; s_err = n_err;
        exp_q = '{8'hEE};
        req();
        k = 0;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                k = i;
                break;
            end
        end
        check("t3_nak_latency", k, TIMEOUT);
        check("t3_nak_byte", bus.tx_data, 8'hEE);
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.error === 1'b1) begin
                got = 1;
                break;
            end
        end
        check("t3_error_seen", 32'(got), 1);
        check("t3_busy_low", bus.busy, 0);
        #1;
        check("t3_no_done", n_done - s_done, 0);
        check("t3_error_pulses", n_err - s_err, 1);
        check_tx("t3_tx");
        @(negedge clk);

        // 4: dump_req while busy is ignored
        s_start = n_start;
        exp_q = '{8'h44, 8'h55, 8'hA5};
        req();
        send_byte(8'h44);
        bus.dump_req = 1'b1;
        @(negedge clk);
        bus.dump_req = 1'b0;
        @(negedge clk);
        check("t4_no_restart", bus.start_dump, 0);
        check("t4_cnt_kept", bus.byte_cnt, 1);
        check("t4_busy", bus.busy, 1);
        send_byte(8'h55);
        finish_dump();
        check("t4_byte_cnt", bus.byte_cnt, 2);
        #1;
        check("t4_start_pulses", n_start - s_start, 1);
        check_tx("t4_tx");
        @(negedge clk);

        // 5: reset while in TX_WAIT
        s_start = n_start; s_sent = n_sent; s_done = n_done; s_err = n_err;
        exp_q = '{8'h77};
        uart_en = 1'b0;
        req();
        bus.ram_rdata = 8'h77;
        bus.send_dump = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                got = 1;
                break;
            end
        end
        check("t5_tx_started", 32'(got), 1);
        check("t5_in_tx_wait", dbg_state, 2);
        rst = 1'b1;
        bus.send_dump = 1'b0;
        @(negedge clk);
        check("t5_rst_state", dbg_state, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_tx_data", bus.tx_data, 0);
        check("t5_rst_tx_start", bus.tx_start, 0);
        check("t5_rst_byte_cnt", bus.byte_cnt, 0);
        rst = 1'b0;
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_idle_after", dbg_state, 0);
        check("t5_busy_after", bus.busy, 0);
        #1;
        check("t5_no_sent", n_sent - s_sent, 0);
        check("t5_no_done_err", (n_done - s_done) + (n_err - s_err), 0);
        check("t5_single_start", n_start - s_start, 1);
        check_tx("t5_tx");
        uart_en = 1'b1;
        @(negedge clk);

        // 6: full 512-byte trace
        uart_delay = 2;
        s_sent = n_sent;
        req();
        for (int i = 0; i < 512; i++) begin
            logic [DATA_W-1:0] b;
            b = 8'((i * 7 + 3) & 255);
            exp_q.push_back(b);
            send_byte(b);
        end
        exp_q.push_back(8'hA5);
        finish_dump();
        check("t6_byte_cnt", bus.byte_cnt, 10'h200);
        #1;
        check("t6_sent_pulses", n_sent - s_sent, 512);
        check_tx("t6_tx");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
